// File: rtl/milestone1_pkg.sv
// Shared types and coin weights for the change dispenser and its helpers.
package milestone1_pkg;

    typedef enum logic [2:0] {IDLE, DROP, SELECT, EJECT, GAP} disp_state_e;
    typedef enum logic {COIN_NICKLE, COIN_DIME} coin_e;

    localparam logic [2:0] NICKLE_UNITS = 3'd1;
    localparam logic [2:0] DIME_UNITS   = 3'd2;

endpackage

// File: rtl/cd_timer.sv
// Loadable down-counter with a zero flag, shared by the soda pulse, ack timeout and coin gap.
module cd_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Drives the soda gate and coin hoppers from the vending FSM result; pays change dimes-first
// with a per-coin hopper handshake, tracks stock and buffers one request while busy.
module change_dispenser
    import milestone1_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 16,
    parameter int NICKLE_MAX   = 15,
    parameter int DIME_MAX     = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_soda,
    input  logic [2:0] i_change,
    input  logic       i_coin_ack,
    input  logic       i_refill_nickle,
    input  logic       i_refill_dime,
    output logic       o_soda_drop,
    output logic       o_eject_nickle,
    output logic       o_eject_dime,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_short,
    output logic       o_fault,
    output logic [3:0] o_nickle_cnt,
    output logic [3:0] o_dime_cnt
);

    localparam int TMAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMAX    = (TMAX_PG > ACK_TIMEOUT) ? TMAX_PG : ACK_TIMEOUT;
    localparam int TMR_W   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TMR_W-1:0] T_PULSE = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_ACK   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       N_FULL  = 4'(NICKLE_MAX);
    localparam logic [3:0]       D_FULL  = 4'(DIME_MAX);

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a - b : 3'd0;
    endfunction

    disp_state_e      r_state;
    coin_e            r_coin;
    logic [2:0]       r_remain;
    logic             r_soda_drop;
    logic             r_eject_n;
    logic             r_eject_d;
    logic             r_done;
    logic             r_short;
    logic             r_fault;
    logic             r_pend_vld;
    logic             r_pend_soda;
    logic [2:0]       r_pend_change;
    logic [3:0]       r_nickle_cnt;
    logic [3:0]       r_dime_cnt;

    logic             w_req;
    logic             w_ack;
    logic             w_dec_n;
    logic             w_dec_d;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;

    assign w_req   = i_soda | (i_change != 3'd0);
    assign w_ack   = (r_state == EJECT) & i_coin_ack;
    assign w_dec_n = w_ack & (r_coin == COIN_NICKLE);
    assign w_dec_d = w_ack & (r_coin == COIN_DIME);

    // The timer is reloaded on the cycle that precedes each timed phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = T_PULSE;
        case (r_state)
            IDLE: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = T_PULSE;
            end
            SELECT: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = T_ACK;
            end
            EJECT: begin
                w_tmr_load = i_coin_ack;
                w_tmr_val  = T_GAP;
            end
            default: begin
                w_tmr_load = 1'b0;
                w_tmr_val  = T_PULSE;
            end
        endcase
    end

    cd_timer #(.W(TMR_W)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    // Refill takes precedence over a same-edge decrement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nickle_cnt <= N_FULL;
            r_dime_cnt   <= D_FULL;
        end else begin
            if (i_refill_nickle) begin
                r_nickle_cnt <= N_FULL;
            end else if (w_dec_n) begin
                r_nickle_cnt <= sat_dec(r_nickle_cnt);
            end
            if (i_refill_dime) begin
                r_dime_cnt <= D_FULL;
            end else if (w_dec_d) begin
                r_dime_cnt <= sat_dec(r_dime_cnt);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_coin        <= COIN_NICKLE;
            r_remain      <= 3'd0;
            r_soda_drop   <= 1'b0;
            r_eject_n     <= 1'b0;
            r_eject_d     <= 1'b0;
            r_done        <= 1'b0;
            r_short       <= 1'b0;
            r_fault       <= 1'b0;
            r_pend_vld    <= 1'b0;
            r_pend_soda   <= 1'b0;
            r_pend_change <= 3'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && w_req) begin
                if (r_pend_vld) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pend_vld    <= 1'b1;
                    r_pend_soda   <= i_soda;
                    r_pend_change <= i_change;
                end
            end
            case (r_state)
                IDLE: begin
                    // A buffered request goes first; a live one arriving now takes its slot.
                    if (r_pend_vld) begin
                        r_remain      <= r_pend_change;
                        r_soda_drop   <= r_pend_soda;
                        r_state       <= r_pend_soda ? DROP : SELECT;
                        r_pend_vld    <= w_req;
                        r_pend_soda   <= i_soda;
                        r_pend_change <= i_change;
                    end else if (w_req) begin
                        r_remain    <= i_change;
                        r_soda_drop <= i_soda;
                        r_state     <= i_soda ? DROP : SELECT;
                    end
                end
                DROP: begin
                    if (w_tmr_zero) begin
                        r_soda_drop <= 1'b0;
                        r_state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (r_remain == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_remain >= DIME_UNITS && r_dime_cnt != 4'd0) begin
                        r_coin    <= COIN_DIME;
                        r_eject_d <= 1'b1;
                        r_state   <= EJECT;
                    end else if (r_nickle_cnt != 4'd0) begin
                        r_coin    <= COIN_NICKLE;
                        r_eject_n <= 1'b1;
                        r_state   <= EJECT;
                    end else begin
                        r_short <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                EJECT: begin
                    if (i_coin_ack) begin
                        r_remain  <= sat_sub(r_remain,
                                             (r_coin == COIN_DIME) ? DIME_UNITS : NICKLE_UNITS);
                        r_eject_n <= 1'b0;
                        r_eject_d <= 1'b0;
                        r_state   <= GAP;
                    end else if (w_tmr_zero) begin
                        r_fault   <= 1'b1;
                        r_remain  <= 3'd0;
                        r_eject_n <= 1'b0;
                        r_eject_d <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                GAP: begin
                    if (w_tmr_zero) begin
                        r_state <= SELECT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_soda_drop    = r_soda_drop;
    assign o_eject_nickle = r_eject_n;
    assign o_eject_dime   = r_eject_d;
    assign o_busy         = (r_state != IDLE);
    assign o_done         = r_done;
    assign o_short        = r_short;
    assign o_fault        = r_fault;
    assign o_nickle_cnt   = r_nickle_cnt;
    assign o_dime_cnt     = r_dime_cnt;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: request table plus hand-written corner sequences, with a
// scoreboard of expected coin ejects and completions checked by a monitor.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int GAPC  = 2;
    localparam int ACKTO = 16;
    localparam int NV    = 13;

    typedef struct {
        bit is_done;
        bit coin_dime;
        bit soda;
        bit short_f;
        bit fault;
    } ev_t;

    typedef struct {
        bit         soda;
        logic [2:0] ch;
        int         ack;
        bit         ref_n;
        bit         ref_d;
        logic [3:0] exp_n;
        logic [3:0] exp_d;
        bit         exp_short;
    } vec_t;

    logic       clk = 1'b0;
    logic       i_rst, i_soda, i_coin_ack, i_refill_nickle, i_refill_dime;
    logic [2:0] i_change;
    logic       o_soda_drop, o_eject_nickle, o_eject_dime, o_busy, o_done, o_short, o_fault;
    logic [3:0] o_nickle_cnt, o_dime_cnt;

    ev_t  q[$];
    vec_t vt[NV];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_n, m_d;
    bit   m_short, m_fault;
    int   ack_dly = 0;
    bit   man_ack = 1'b0;

    always #5 clk = ~clk;

    change_dispenser dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_soda          (i_soda),
        .i_change        (i_change),
        .i_coin_ack      (i_coin_ack),
        .i_refill_nickle (i_refill_nickle),
        .i_refill_dime   (i_refill_dime),
        .o_soda_drop     (o_soda_drop),
        .o_eject_nickle  (o_eject_nickle),
        .o_eject_dime    (o_eject_dime),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_short         (o_short),
        .o_fault         (o_fault),
        .o_nickle_cnt    (o_nickle_cnt),
        .o_dime_cnt      (o_dime_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Greedy payout model: queues the coins a request should eject, then its completion.
    task automatic push_req(input bit soda, input logic [2:0] ch, input bit ack_ok);
        int  rem;
        bit  dime;
        ev_t e;
        rem = int'(ch);
        while (rem > 0) begin
            if (rem >= 2 && m_d > 0) dime = 1'b1;
            else if (m_n > 0) dime = 1'b0;
            else begin
                m_short = 1'b1;
                break;
            end
            e = '{default: 0};
            e.coin_dime = dime;
            q.push_back(e);
            if (!ack_ok) begin
                m_fault = 1'b1;
                break;
            end
            if (dime) begin m_d--; rem -= 2; end
            else begin m_n--; rem -= 1; end
        end
        e = '{default: 0};
        e.is_done = 1'b1;
        e.soda    = soda;
        e.short_f = m_short;
        e.fault   = m_fault;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !o_busy) break;
        end
        if (k == 400) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: busy=%0d, %0d expected events outstanding", name, o_busy, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        q.delete();
        m_n = 15; m_d = 15; m_short = 1'b0; m_fault = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_drop"},  o_soda_drop,    0);
        chk({tag, "_ejn"},   o_eject_nickle, 0);
        chk({tag, "_ejd"},   o_eject_dime,   0);
        chk({tag, "_busy"},  o_busy,         0);
        chk({tag, "_done"},  o_done,         0);
        chk({tag, "_short"}, o_short,        0);
        chk({tag, "_fault"}, o_fault,        0);
        chk({tag, "_ncnt"},  o_nickle_cnt,   15);
        chk({tag, "_dcnt"},  o_dime_cnt,     15);
    endtask

    task automatic send(input bit soda, input logic [2:0] ch, input bit ack_ok);
        @(negedge clk);
        i_soda = soda; i_change = ch;
        push_req(soda, ch, ack_ok);
        @(negedge clk);
        i_soda = 1'b0; i_change = 3'd0;
    endtask

    // Hopper model: acks after ack_dly cycles of a held eject line.
    initial begin
        int hold;
        hold = 0;
        i_coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (o_eject_nickle | o_eject_dime) begin
                i_coin_ack = (hold == ack_dly) | man_ack;
                hold++;
            end else begin
                hold = 0;
                i_coin_ack = man_ack;
            end
        end
    end

    // Monitor: pops the scoreboard on each eject start and each completion.
    initial begin
        bit  pe, ps, cur, gap_armed;
        int  drop_run, low_run, drops_seen;
        ev_t e;
        pe = 0; ps = 0; gap_armed = 0; drop_run = 0; low_run = 0; drops_seen = 0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                pe = 0; ps = 0; gap_armed = 0; drop_run = 0; low_run = 0; drops_seen = 0;
            end else begin
                cur = o_eject_nickle | o_eject_dime;
                if (o_soda_drop) drop_run++;
                else if (ps) begin
                    chk("drop_width", drop_run, PULSE);
                    drop_run = 0;
                    drops_seen++;
                end
                if (cur && !pe) begin
                    chk("eject_onehot", o_eject_nickle & o_eject_dime, 0);
                    if (gap_armed) chk("gap_len", low_run, GAPC + 1);
                    gap_armed = 0;
                    if (q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL eject_unexpected: got dime=%0d, want no eject", o_eject_dime);
                    end else begin
                        e = q.pop_front();
                        chk("ev_is_coin", e.is_done, 0);
                        chk("coin_type_dime", o_eject_dime, e.coin_dime);
                    end
                end
                if (!cur && pe) begin
                    gap_armed = 1; low_run = 1;
                end else if (!cur && gap_armed) low_run++;
                if (o_done) begin
                    if (q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL done_unexpected: got o_done=1, want 0");
                    end else begin
                        e = q.pop_front();
                        chk("ev_is_done", e.is_done, 1);
                        chk("done_short", o_short, e.short_f);
                        chk("done_fault", o_fault, e.fault);
                        chk("done_drops", drops_seen, e.soda);
                        chk("done_busy", o_busy, 0);
                    end
                    drops_seen = 0;
                    gap_armed = 0;
                end
                pe = cur;
                ps = o_soda_drop;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d events outstanding", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        i_rst = 1'b1; i_soda = 1'b0; i_change = 3'd0;
        i_refill_nickle = 1'b0; i_refill_dime = 1'b0;

        //            soda ch    ack rn rd  exp_n  exp_d  short
        vt[0]  = '{1'b1, 3'd0, 0, 0, 0, 4'd15, 4'd15, 1'b0};
        vt[1]  = '{1'b1, 3'd2, 0, 0, 0, 4'd15, 4'd14, 1'b0};
        vt[2]  = '{1'b1, 3'd3, 3, 0, 0, 4'd14, 4'd13, 1'b0};
        vt[3]  = '{1'b0, 3'd7, 1, 0, 0, 4'd13, 4'd10, 1'b0};
        vt[4]  = '{1'b0, 3'd5, 0, 0, 0, 4'd12, 4'd8,  1'b0};
        vt[5]  = '{1'b0, 3'd7, 2, 0, 0, 4'd11, 4'd5,  1'b0};
        vt[6]  = '{1'b0, 3'd7, 0, 0, 0, 4'd10, 4'd2,  1'b0};
        vt[7]  = '{1'b0, 3'd7, 1, 0, 0, 4'd7,  4'd0,  1'b0};
        vt[8]  = '{1'b0, 3'd4, 0, 0, 0, 4'd3,  4'd0,  1'b0};
        vt[9]  = '{1'b1, 3'd5, 0, 0, 0, 4'd0,  4'd0,  1'b1};
        vt[10] = '{1'b0, 3'd1, 0, 0, 1, 4'd0,  4'd15, 1'b1};
        vt[11] = '{1'b0, 3'd1, 0, 1, 0, 4'd14, 4'd15, 1'b1};
        vt[12] = '{1'b1, 3'd6, 2, 0, 0, 4'd14, 4'd12, 1'b1};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < NV; i++) begin
            ack_dly = vt[i].ack;
            @(negedge clk);
            i_refill_nickle = vt[i].ref_n;
            i_refill_dime   = vt[i].ref_d;
            if (vt[i].ref_n) m_n = 15;
            if (vt[i].ref_d) m_d = 15;
            @(negedge clk);
            i_refill_nickle = 1'b0; i_refill_dime = 1'b0;
            i_soda = vt[i].soda; i_change = vt[i].ch;
            push_req(vt[i].soda, vt[i].ch, 1'b1);
            @(negedge clk);
            i_soda = 1'b0; i_change = 3'd0;
            if (vt[i].soda) chk("accept_drop", o_soda_drop, 1);
            else chk("accept_busy", o_busy, 1);
            wait_idle("vec");
            chk("vec_ncnt", o_nickle_cnt, vt[i].exp_n);
            chk("vec_dcnt", o_dime_cnt, vt[i].exp_d);
            chk("vec_short", o_short, vt[i].exp_short);
        end

        // Ack while idle must not touch stock or start anything.
        @(negedge clk); man_ack = 1'b1;
        repeat (3) @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ack_ncnt", o_nickle_cnt, 14);
        chk("idle_ack_dcnt", o_dime_cnt, 12);
        chk("idle_ack_busy", o_busy, 0);

        // Refill on the same edge as a nickle ack leaves the stock full.
        do_reset();
        ack_dly = 0;
        send(1'b0, 3'd1, 1'b1);
        wait_idle("pre_refill");
        chk("pre_refill_ncnt", o_nickle_cnt, 14);
        ack_dly = 2;
        send(1'b0, 3'd1, 1'b1);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_eject_nickle) break;
        end
        chk("refill_eject_seen", o_eject_nickle, 1);
        repeat (2) @(negedge clk);
        i_refill_nickle = 1'b1;
        @(negedge clk);
        i_refill_nickle = 1'b0;
        m_n = 15;
        wait_idle("refill_race");
        chk("refill_race_ncnt", o_nickle_cnt, 15);

        // Hopper never acks: abort after the timeout with stock untouched.
        do_reset();
        ack_dly = 1000;
        send(1'b0, 3'd1, 1'b0);
        k = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (o_eject_nickle) k++;
            if (o_done) break;
        end
        chk("timeout_len", k, ACKTO);
        wait_idle("timeout");
        chk("timeout_fault", o_fault, 1);
        chk("timeout_ncnt", o_nickle_cnt, 15);

        // Second request buffered during DROP, third dropped with a fault.
        do_reset();
        ack_dly = 0;
        m_fault = 1'b1;
        send(1'b1, 3'd0, 1'b1);
        @(negedge clk);
        i_soda = 1'b1; i_change = 3'd2;
        push_req(1'b1, 3'd2, 1'b1);
        @(negedge clk);
        i_soda = 1'b0; i_change = 3'd1;
        @(negedge clk);
        i_change = 3'd0;
        wait_idle("pending");
        chk("pending_fault", o_fault, 1);
        chk("pending_dcnt", o_dime_cnt, 14);
        chk("pending_ncnt", o_nickle_cnt, 15);

        // Reset while a dime is ejecting.
        do_reset();
        ack_dly = 1000;
        send(1'b0, 3'd2, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_eject_dime", o_eject_dime, 1);
        i_rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        i_rst = 1'b0;
        q.delete();
        ack_dly = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", o_busy, 0);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
